// File: rtl/matrix_result_streamer_if.sv
// Handshake bundle for matrix_result_streamer: capture side (in_*, MP) and element stream side (out_*).
interface matrix_result_streamer_if #(
    parameter int unsigned word_size     = 32,
    parameter int unsigned Amatrixrownum = 2,
    parameter int unsigned Bmatrixcolnum = 1
);
    localparam int unsigned N  = Amatrixrownum * Bmatrixcolnum;
    localparam int unsigned RW = $clog2((Amatrixrownum > 2) ? Amatrixrownum : 2);
    localparam int unsigned CW = $clog2((Bmatrixcolnum > 2) ? Bmatrixcolnum : 2);

    logic                     in_valid;
    logic                     in_ready;
    logic [N*word_size-1:0]   MP;
    logic                     out_valid;
    logic                     out_ready;
    logic [word_size-1:0]     out_data;
    logic [RW-1:0]            out_row;
    logic [CW-1:0]            out_col;
    logic                     out_last;
    logic                     busy;

    modport master (
        input  in_valid, MP, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );

    modport slave (
        output in_valid, MP, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last, busy
    );
endinterface

// File: rtl/matrix_result_streamer.sv
// Captures a flattened row-major matrix result once and serialises it as one
// tagged element per valid/ready transfer.
module matrix_result_streamer #(
    parameter int unsigned word_size     = 32,
    parameter int unsigned Amatrixrownum = 2,
    parameter int unsigned Bmatrixcolnum = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    matrix_result_streamer_if.master     bus
);
    localparam int unsigned N  = Amatrixrownum * Bmatrixcolnum;
    localparam int unsigned VW = N * word_size;
    localparam int unsigned RW = $clog2((Amatrixrownum > 2) ? Amatrixrownum : 2);
    localparam int unsigned CW = $clog2((Bmatrixcolnum > 2) ? Bmatrixcolnum : 2);
    localparam int unsigned KW = $clog2((N > 2) ? N : 2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [VW-1:0]        hold_q, hold_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 valid_q, valid_d;
    logic [word_size-1:0] data_q, data_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 last_q, last_d;

    // Holding register shifts left on each advance so the current element sits in the MSBs.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        k_d     = k_q;
        valid_d = valid_q;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_d  = bus.MP;
                    data_d  = bus.MP[VW-1 -: word_size];
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = (N == 1);
                    valid_d = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && bus.out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q << word_size;
                        data_d = hold_d[VW-1 -: word_size];
                        k_d    = k_q + KW'(1);
                        last_d = (k_d == KW'(N - 1));
                        if (col_q == CW'(Bmatrixcolnum - 1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            k_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q == STREAM);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Scoreboard bench for matrix_result_streamer in 2x2/8b, 1x1/16b and 3x1/8b configurations.
module tb_matrix_result_streamer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_result_streamer_if #(.word_size(8),  .Amatrixrownum(2), .Bmatrixcolnum(2)) b2();
    matrix_result_streamer_if #(.word_size(16), .Amatrixrownum(1), .Bmatrixcolnum(1)) b1();
    matrix_result_streamer_if #(.word_size(8),  .Amatrixrownum(3), .Bmatrixcolnum(1)) b3();

    matrix_result_streamer #(.word_size(8),  .Amatrixrownum(2), .Bmatrixcolnum(2)) u2 (.clk(clk), .rst(rst), .bus(b2.master));
    matrix_result_streamer #(.word_size(16), .Amatrixrownum(1), .Bmatrixcolnum(1)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
    matrix_result_streamer #(.word_size(8),  .Amatrixrownum(3), .Bmatrixcolnum(1)) u3 (.clk(clk), .rst(rst), .bus(b3.master));

    typedef struct {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } exp_t;

    exp_t q2[$];
    exp_t q1[$];
    exp_t q3[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input logic [15:0] d, input logic [1:0] r,
                       input logic [1:0] c, input logic l, input exp_t e);
        check({tag, "_data"}, 32'(d), 32'(e.data));
        check({tag, "_row"},  32'(r), 32'(e.row));
        check({tag, "_col"},  32'(c), 32'(e.col));
        check({tag, "_last"}, 32'(l), 32'(e.last));
    endtask

    task automatic unexpected(input string tag, input logic [15:0] d);
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got element %0h expected none at %0t", tag, d, $time);
    endtask

    // Monitors: compare every valid cycle (stalls included) against the queue head; pop on transfer.
    always @(negedge clk) begin
        if (!rst && b2.out_valid) begin
            if (q2.size() == 0) unexpected("m2", 16'(b2.out_data));
            else begin
                cmp("m2", 16'(b2.out_data), 2'(b2.out_row), 2'(b2.out_col), b2.out_last, q2[0]);
                if (b2.out_ready) void'(q2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b1.out_valid) begin
            if (q1.size() == 0) unexpected("m1", 16'(b1.out_data));
            else begin
                cmp("m1", 16'(b1.out_data), 2'(b1.out_row), 2'(b1.out_col), b1.out_last, q1[0]);
                if (b1.out_ready) void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b3.out_valid) begin
            if (q3.size() == 0) unexpected("m3", 16'(b3.out_data));
            else begin
                cmp("m3", 16'(b3.out_data), 2'(b3.out_row), 2'(b3.out_col), b3.out_last, q3[0]);
                if (b3.out_ready) void'(q3.pop_front());
            end
        end
    end

    task automatic exp2(input logic [7:0] d, input int r, input int c, input bit l);
        q2.push_back('{16'(d), 2'(r), 2'(c), l});
    endtask

    task automatic exp3(input logic [7:0] d, input int r, input int c, input bit l);
        q3.push_back('{16'(d), 2'(r), 2'(c), l});
    endtask

    function automatic int qsize(input int which);
        case (which)
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    // Single-cycle capture on the 2x2 instance; called at posedge+1 with the DUT in IDLE.
    task automatic capture2(input logic [31:0] mp);
        check("cap2_in_ready", 32'(b2.in_ready), 32'd1);
        b2.in_valid = 1'b1;
        b2.MP       = mp;
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    // Run until the scoreboard empties (bounded) and check the cycle count.
    task automatic drain(input int which, input int exp_n, input bit toggle);
        bit pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};
        int n = 0;
        int p = 0;
        while (qsize(which) != 0 && n < 100) begin
            if (toggle) begin
                b2.out_ready = pat[p % 12];
                p++;
            end
            @(posedge clk); #1;
            n++;
        end
        b2.out_ready = 1'b1;
        check($sformatf("drain%0d_left", which), 32'(qsize(which)), 32'd0);
        check($sformatf("drain%0d_cycles", which), 32'(n), 32'(exp_n));
    endtask

    initial begin
        b2.in_valid = 1'b0; b2.MP = '0; b2.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.MP = '0; b1.out_ready = 1'b1;
        b3.in_valid = 1'b0; b3.MP = '0; b3.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(b2.in_ready),  32'd0);
        check("rst_out_valid", 32'(b2.out_valid), 32'd0);
        check("rst_out_data",  32'(b2.out_data),  32'd0);
        check("rst_out_row",   32'(b2.out_row),   32'd0);
        check("rst_out_col",   32'(b2.out_col),   32'd0);
        check("rst_out_last",  32'(b2.out_last),  32'd0);
        check("rst_busy",      32'(b2.busy),      32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(b2.in_ready), 32'd1);

        // 1: 2x2 full-rate stream
        @(posedge clk); #1;
        exp2(8'h11, 0, 0, 0); exp2(8'h22, 0, 1, 0); exp2(8'h33, 1, 0, 0); exp2(8'h44, 1, 1, 1);
        capture2(32'h11223344);
        check("t1_busy", 32'(b2.busy), 32'd1);
        drain(2, 4, 0);
        check("t1_in_ready_after", 32'(b2.in_ready),  32'd1);
        check("t1_valid_after",    32'(b2.out_valid), 32'd0);
        check("t1_busy_after",     32'(b2.busy),      32'd0);

        // 2: back-pressure pattern 1,0,0,1,0,1,1
        exp2(8'h11, 0, 0, 0); exp2(8'h22, 0, 1, 0); exp2(8'h33, 1, 0, 0); exp2(8'h44, 1, 1, 1);
        capture2(32'h11223344);
        drain(2, 7, 1);

        // 3: MP changes mid-stream with in_valid held high
        exp2(8'h11, 0, 0, 0); exp2(8'h22, 0, 1, 0); exp2(8'h33, 1, 0, 0); exp2(8'h44, 1, 1, 1);
        exp2(8'hDE, 0, 0, 0); exp2(8'hAD, 0, 1, 0); exp2(8'hBE, 1, 0, 0); exp2(8'hEF, 1, 1, 1);
        b2.in_valid = 1'b1;
        b2.MP       = 32'h11223344;
        @(posedge clk); #1;
        b2.MP = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            check("t3_in_ready_stream", 32'(b2.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("t3_in_ready_idle", 32'(b2.in_ready), 32'd1);
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
        drain(2, 4, 0);

        // 4: reset after the second transfer, then a fresh capture
        exp2(8'h11, 0, 0, 0); exp2(8'h22, 0, 1, 0);
        capture2(32'h11223344);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t4_out_valid", 32'(b2.out_valid), 32'd0);
        check("t4_busy",      32'(b2.busy),      32'd0);
        check("t4_in_ready",  32'(b2.in_ready),  32'd1);
        check("t4_q_empty",   32'(q2.size()),    32'd0);
        @(posedge clk); #1;
        exp2(8'hA1, 0, 0, 0); exp2(8'hB2, 0, 1, 0); exp2(8'hC3, 1, 0, 0); exp2(8'hD4, 1, 1, 1);
        capture2(32'hA1B2C3D4);
        drain(2, 4, 0);

        // 5: 1x1, 16-bit
        q1.push_back('{16'hBEEF, 2'd0, 2'd0, 1'b1});
        check("t5_in_ready", 32'(b1.in_ready), 32'd1);
        b1.in_valid = 1'b1;
        b1.MP       = 16'hBEEF;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        check("t5_busy",      32'(b1.busy),      32'd1);
        check("t5_out_valid", 32'(b1.out_valid), 32'd1);
        @(posedge clk); #1;
        check("t5_in_ready_after", 32'(b1.in_ready),  32'd1);
        check("t5_valid_after",    32'(b1.out_valid), 32'd0);
        check("t5_busy_after",     32'(b1.busy),      32'd0);
        check("t5_q_empty",        32'(q1.size()),    32'd0);

        // 6: 3x1, 8-bit
        exp3(8'h01, 0, 0, 0); exp3(8'h02, 1, 0, 0); exp3(8'h03, 2, 0, 1);
        check("t6_in_ready", 32'(b3.in_ready), 32'd1);
        b3.in_valid = 1'b1;
        b3.MP       = 24'h010203;
        @(posedge clk); #1;
        b3.in_valid = 1'b0;
        drain(3, 3, 0);
        check("t6_in_ready_after", 32'(b3.in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("end_q2_empty", 32'(q2.size()), 32'd0);
        check("end_q1_empty", 32'(q1.size()), 32'd0);
        check("end_q3_empty", 32'(q3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
